// File: rtl/debug_loader.sv
// rtl/debug_loader.sv - UART byte-frame parser driving the core debug memory-write port
module debug_loader #(
    parameter int TimeoutCycles = 1_000_000,
    parameter int AddrWidth     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_data_i,
    output logic                 debug_o,
    output logic                 debug_we_o,
    output logic [AddrWidth-1:0] debug_addr_o,
    output logic [31:0]          debug_data_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic                 done_o,
    output logic                 error_o
);
    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;
    localparam int TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_COUNT, S_DATA, S_CHK, S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             chk_q, chk_d;
    logic                   run_q, run_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [31:0]            shift_q, shift_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [15:0]            words_q, words_d;
    logic [7:0]             resp_q, resp_d;
    logic                   debug_q, debug_d;
    logic                   we_q, we_d;
    logic [AddrWidth-1:0]   waddr_q, waddr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;

    logic        parsing;
    logic        timeout_fire;
    logic [31:0] rx_word;
    logic [15:0] rx_count;

    // Bytes arrive little-endian, so each new byte enters at the top of the shifter.
    assign rx_word      = {rx_data_i, shift_q[31:8]};
    assign rx_count     = {rx_data_i, shift_q[31:24]};
    assign parsing      = (state_q != S_IDLE) && (state_q != S_RESP);
    assign timeout_fire = parsing && !rx_valid_i && (tmo_q == TmoLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            chk_q   <= '0;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            words_q <= '0;
            resp_q  <= '0;
            debug_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            resp_q  <= resp_d;
            debug_q <= debug_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout_fire) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (rx_valid_i && rx_data_i == SYNC) state_d = S_CMD;
                S_CMD: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == CMD_LOAD)     state_d = S_ADDR;
                        else if (rx_data_i == CMD_RUN) state_d = S_CHK;
                        else                           state_d = S_RESP;
                    end
                end
                S_ADDR:  if (rx_valid_i && cnt_q == 2'd3) state_d = S_COUNT;
                S_COUNT: begin
                    if (rx_valid_i && cnt_q == 2'd1)
                        state_d = (rx_count == 16'd0) ? S_CHK : S_DATA;
                end
                S_DATA:  if (rx_valid_i && cnt_q == 2'd3 && words_q == 16'd1) state_d = S_CHK;
                S_CHK:   if (rx_valid_i) state_d = S_RESP;
                S_RESP:  if (tx_ready_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        chk_d   = chk_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        words_d = words_q;
        resp_d  = resp_q;
        debug_d = debug_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        error_d = error_q;
        tmo_d   = tmo_q;

        if (!parsing || rx_valid_i)
            tmo_d = '0;
        else if (tmo_q != TmoLast)
            tmo_d = tmo_q + TmoW'(1);

        if (timeout_fire)
            error_d = 1'b1;

        if (rx_valid_i) begin
            if (state_q != S_IDLE && state_q != S_RESP && state_q != S_CHK)
                chk_d = chk_q ^ rx_data_i;
            case (state_q)
                S_IDLE: begin
                    if (rx_data_i == SYNC) begin
                        chk_d   = '0;
                        cnt_d   = '0;
                        error_d = 1'b0;
                    end
                end
                S_CMD: begin
                    cnt_d = '0;
                    if (rx_data_i == CMD_LOAD) begin
                        debug_d = 1'b1;
                        run_d   = 1'b0;
                    end else if (rx_data_i == CMD_RUN) begin
                        run_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        resp_d  = NAK;
                    end
                end
                S_ADDR: begin
                    shift_d = rx_word;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) addr_d = AddrWidth'(rx_word);
                end
                S_COUNT: begin
                    shift_d = rx_word;
                    if (cnt_q == 2'd1) begin
                        words_d = rx_count;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                    end
                end
                S_DATA: begin
                    shift_d = rx_word;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = rx_word;
                        addr_d  = addr_q + AddrWidth'(4);
                        words_d = words_q - 16'd1;
                    end
                end
                S_CHK: begin
                    if (rx_data_i == chk_q) begin
                        resp_d = ACK;
                    end else begin
                        resp_d  = NAK;
                        error_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (state_q == S_RESP && tx_ready_i && resp_q == ACK) begin
            done_d = 1'b1;
            if (run_q) debug_d = 1'b0;
        end
    end

    always_comb begin
        debug_o      = debug_q;
        debug_we_o   = we_q;
        debug_addr_o = waddr_q;
        debug_data_o = wdata_q;
        tx_valid_o   = (state_q == S_RESP);
        tx_data_o    = (state_q == S_RESP) ? resp_q : 8'h00;
        done_o       = done_q;
        error_o      = error_q;
    end
endmodule

// File: tb/tb_debug_loader.sv
// tb/tb_debug_loader.sv - randomized scoreboard bench for debug_loader
`timescale 1ns/1ps
module tb_debug_loader;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        tx_ready_i = 1'b0;
    logic        debug_o, debug_we_o, tx_valid_o, done_o, error_o;
    logic [31:0] debug_addr_o, debug_data_o;
    logic [7:0]  tx_data_o;

    debug_loader #(.TimeoutCycles(100), .AddrWidth(32)) dut (
        .clk(clk), .reset(reset),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .debug_o(debug_o), .debug_we_o(debug_we_o),
        .debug_addr_o(debug_addr_o), .debug_data_o(debug_data_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .done_o(done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] exp_wr[$];
    logic [7:0]  exp_resp[$];
    int          exp_done = 0;
    int          done_seen = 0;
    logic        m_debug = 1'b0;
    logic        m_error = 1'b0;
    int          rdy_mode = 0;
    logic        tx_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got %0h want nothing", name, act);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready_i = ($urandom_range(0, 3) != 0);
                1:       tx_ready_i = 1'b0;
                default: tx_ready_i = 1'b1;
            endcase
        end
    end

    logic       prev_we = 1'b0, prev_done = 1'b0, prev_hold = 1'b0;
    logic [7:0] prev_tx = 8'h00;
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset) begin
            prev_we = 1'b0; prev_done = 1'b0; prev_hold = 1'b0;
        end else begin
            if (debug_we_o) begin
                chk("we_single", prev_we, 0);
                if (exp_wr.size() == 0) fail_now("wr_unexpected", {debug_addr_o, debug_data_o});
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", debug_addr_o, e[63:32]);
                    chk("wr_data", debug_data_o, e[31:0]);
                end
            end
            if (prev_hold) chk("tx_hold", {tx_valid_o, tx_data_o}, {1'b1, prev_tx});
            if (tx_valid_o) tx_seen = 1'b1;
            if (tx_valid_o && tx_ready_i) begin
                if (exp_resp.size() == 0) fail_now("tx_unexpected", tx_data_o);
                else chk("tx_data", tx_data_o, exp_resp.pop_front());
            end
            if (done_o) begin
                chk("done_single", prev_done, 0);
                done_seen++;
            end
            prev_we   = debug_we_o;
            prev_done = done_o;
            prev_hold = tx_valid_o && !tx_ready_i;
            prev_tx   = tx_data_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bq_t b, input int gap_max);
        foreach (b[i]) begin
            rx_valid_i = 1'b1;
            rx_data_i  = b[i];
            step();
            rx_valid_i = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
        end
    endtask

    // Reference model: interprets a whole frame by the protocol rules.
    task automatic model_frame(input bq_t b);
        logic [7:0]  x;
        logic [31:0] a, w;
        int          cnt, n;
        n = b.size();
        m_error = 1'b0;
        if (b[1] != 8'h01 && b[1] != 8'h02) begin
            exp_resp.push_back(8'h15);
            m_error = 1'b1;
            return;
        end
        if (b[1] == 8'h01) begin
            m_debug = 1'b1;
            a   = {b[5], b[4], b[3], b[2]};
            cnt = {b[7], b[6]};
            for (int k = 0; k < cnt; k++) begin
                w = {b[11+4*k], b[10+4*k], b[9+4*k], b[8+4*k]};
                exp_wr.push_back({a + 32'(4*k), w});
            end
        end
        x = 8'h00;
        for (int i = 1; i < n - 1; i++) x ^= b[i];
        if (x == b[n-1]) begin
            exp_resp.push_back(8'h06);
            exp_done++;
            if (b[1] == 8'h02) m_debug = 1'b0;
        end else begin
            exp_resp.push_back(8'h15);
            m_error = 1'b1;
        end
    endtask

    task automatic mk_load(input logic [31:0] addr, input int cnt, input bit bad, output bq_t b);
        logic [31:0] w;
        logic [7:0]  x;
        b = {};
        b.push_back(8'hA5);
        b.push_back(8'h01);
        for (int i = 0; i < 4; i++) b.push_back(addr[8*i +: 8]);
        b.push_back(cnt[7:0]);
        b.push_back(cnt[15:8]);
        for (int k = 0; k < cnt; k++) begin
            w = $urandom;
            for (int i = 0; i < 4; i++) b.push_back(w[8*i +: 8]);
        end
        x = 8'h00;
        for (int i = 1; i < b.size(); i++) x ^= b[i];
        b.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_resp.size() != 0 && k < 400) begin
            step();
            k++;
        end
        chk("resp_drained", exp_resp.size(), 0);
        repeat (3) step();
        chk("done_count", done_seen, exp_done);
        chk("debug_o", debug_o, m_debug);
        chk("error_o", error_o, m_error);
        chk("wr_drained", exp_wr.size(), 0);
    endtask

    task automatic run_frame(input bq_t b, input int gap_max);
        model_frame(b);
        send(b, gap_max);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_debug"}, debug_o, 0);
        chk({tag, "_we"}, debug_we_o, 0);
        chk({tag, "_addr"}, debug_addr_o, 0);
        chk({tag, "_data"}, debug_data_o, 0);
        chk({tag, "_txv"}, tx_valid_o, 0);
        chk({tag, "_txd"}, tx_data_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, error_o, 0);
    endtask

    initial begin
        bq_t  b, part, junk;
        logic [7:0] x;
        int   kind;

        #1;
        check_reset_outputs("rst0");
        repeat (3) step();
        reset = 1'b1;
        step();

        b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        x = 8'h00;
        for (int i = 1; i < b.size(); i++) x ^= b[i];
        part = b;
        part.push_back(x);
        run_frame(part, 0);
        part = b;
        part.push_back(x ^ 8'h01);
        run_frame(part, 1);

        b = '{8'hA5, 8'h02, 8'h02};
        run_frame(b, 2);

        mk_load(32'hFFFF_FFFC, 2, 1'b0, b);
        run_frame(b, 0);
        mk_load($urandom, 0, 1'b0, b);
        run_frame(b, 1);
        b = '{8'hA5, 8'h7E};
        run_frame(b, 0);

        for (int it = 0; it < 14; it++) begin
            junk = {};
            repeat ($urandom_range(0, 3)) begin
                x = 8'($urandom_range(0, 255));
                junk.push_back(x == 8'hA5 ? 8'h00 : x);
            end
            send(junk, 1);
            kind = $urandom_range(0, 9);
            if (kind <= 5) mk_load($urandom, $urandom_range(0, 4), ($urandom_range(0, 3) == 0), b);
            else if (kind <= 7) b = '{8'hA5, 8'h02, 8'h02};
            else if (kind == 8) b = '{8'hA5, 8'h02, 8'h03};
            else b = '{8'hA5, 8'h33};
            run_frame(b, $urandom_range(0, 2));
        end

        b = '{8'hA5, 8'h01, 8'h00};
        send(b, 0);
        m_debug = 1'b1;
        tx_seen = 1'b0;
        repeat (95) step();
        chk("tmo_early", error_o, 0);
        repeat (15) step();
        chk("tmo_error", error_o, 1);
        chk("tmo_no_tx", tx_seen, 0);
        chk("tmo_debug", debug_o, 1);
        m_error = 1'b1;
        b = '{8'hA5, 8'h02, 8'h02};
        run_frame(b, 0);

        rdy_mode = 1;
        step();
        mk_load($urandom, 1, 1'b0, b);
        model_frame(b);
        send(b, 0);
        junk = '{8'hA5, 8'h02, 8'h02, 8'h33};
        send(junk, 3);
        repeat (40) step();
        chk("bp_valid", tx_valid_o, 1);
        chk("bp_data", tx_data_o, 8'h06);
        rdy_mode = 0;
        wait_done();

        mk_load(32'h0000_1000, 3, 1'b0, b);
        part = {};
        for (int i = 0; i < 14; i++) part.push_back(b[i]);
        m_debug = 1'b1;
        exp_wr.push_back({32'h0000_1000, b[11], b[10], b[9], b[8]});
        send(part, 0);
        step();
        chk("rst_wr_seen", exp_wr.size(), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_wr.delete();
        exp_resp.delete();
        m_debug = 1'b0;
        m_error = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        mk_load($urandom, 2, 1'b0, b);
        run_frame(b, 1);
        b = '{8'hA5, 8'h02, 8'h02};
        run_frame(b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/debug_loader.md
# debug_loader

Host-to-core program loader for the Arty top. Parses a byte-framed command stream from the UART receiver and drives the core's debug memory-write interface (`debug_i`, `debug_addr_i`, `debug_data_i`) to fill IMEM/DMEM. It holds the core in debug while loading and releases it on command. Each frame is acknowledged with an ACK/NAK byte on the UART transmit path.

## Interface
- `TimeoutCycles`, default 1_000_000: maximum idle cycles between bytes inside a frame before the frame is abandoned.
- `AddrWidth`, default 32: width of `debug_addr_o`.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_valid_i`  in  1  one-cycle strobe, received byte on `rx_data_i`.
- `rx_data_i`  in  8  received byte.
- `debug_o`  out  1  core held in debug mode (drives top `debug_i`).
- `debug_we_o`  out  1  one-cycle memory write strobe.
- `debug_addr_o`  out  AddrWidth  byte address of the write.
- `debug_data_o`  out  32  write word.
- `tx_valid_o`  out  1  response byte valid.
- `tx_data_o`  out  8  response byte.
- `tx_ready_i`  in  1  transmitter accepts byte when high with `tx_valid_o`.
- `done_o`  out  1  one-cycle pulse when a frame completes with ACK.
- `error_o`  out  1  sticky error flag; cleared when the next SYNC is accepted.

## Operation
- Frame: SYNC 0xA5, CMD, body, CHK. CHK is the XOR of all bytes after SYNC and before CHK.
- CMD 0x01 LOAD: body is ADDR (4 bytes, LE), COUNT (2 bytes, LE, number of words, 0 legal), then COUNT×4 data bytes (LE per word).
- CMD 0x02 RUN: empty body.
- States: IDLE → CMD → (LOAD: ADDR → COUNT → DATA or CHK if COUNT=0) / (RUN: CHK) → RESP → IDLE.
- IDLE: bytes other than 0xA5 are discarded.
- LOAD sets `debug_o`=1 when CMD 0x01 is accepted. It stays 1 after the frame.
- RUN with a good CHK clears `debug_o` in the cycle the ACK is accepted. RUN with a bad CHK leaves `debug_o` unchanged.
- DATA: when the 4th byte of a word arrives, the following cycle drives `debug_we_o`=1 with the current address and word. The address then increments by 4, wrapping modulo 2^AddrWidth. After COUNT words the FSM enters CHK.
- Writes are not buffered. A bad CHK does not undo earlier writes.
- CHK good: response 0x06 (ACK), `done_o` pulses when the ACK is accepted.
- CHK bad: response 0x15 (NAK), `error_o`=1.
- Unknown CMD: `error_o`=1, response NAK, no further bytes are parsed.
- RESP: hold `tx_valid_o`=1 and `tx_data_o` stable until `tx_ready_i`=1, then return to IDLE. `rx_valid_i` bytes arriving in RESP are dropped.
- Timeout: in any state except IDLE/RESP, if `TimeoutCycles` consecutive cycles pass without `rx_valid_i`, go to IDLE, set `error_o`=1, send no response. `debug_o` keeps its value.

## Timing
- Reset values: state IDLE; `debug_o`=0, `debug_we_o`=0, `debug_addr_o`=0, `debug_data_o`=0, `tx_valid_o`=0, `tx_data_o`=0, `done_o`=0, `error_o`=0.
- Reset mid-frame aborts immediately. No write strobe or response follows.
- Write latency: `debug_we_o` is high exactly 1 cycle after the `rx_valid_i` of the word's 4th byte.
- Byte to response: `tx_valid_o` rises 1 cycle after the CHK byte strobe.
- `rx_valid_i` in back-to-back cycles must be accepted without loss in all parsing states.
- A `debug_we_o` cycle coinciding with the next byte strobe must be handled with no stall.
- The timeout counter resets on every `rx_valid_i` and saturates; it is only active outside IDLE/RESP.
- `done_o` and `debug_we_o` are never high for more than one consecutive cycle each.

## Test plan
- LOAD of 2 words: bytes A5 01 00 00 00 00 02 00 EF BE AD DE 78 56 34 12 plus correct CHK.
  - Required: `debug_we_o` pulses (0x0, 0xDEADBEEF) then (0x4, 0x12345678).
  - Required: `debug_o`=1, `tx_data_o`=0x06, `done_o` pulse.
- Same frame with CHK^0x01 → both writes still occur, NAK 0x15, `error_o`=1, no `done_o`.
- RUN frame A5 02 02 after a LOAD → ACK 0x06; `debug_o` falls when `tx_ready_i` is accepted.
- Address wrap: LOAD at 0xFFFFFFFC with COUNT=2 → writes at 0xFFFFFFFC then 0x00000000.
- Timeout (`TimeoutCycles`=100): send A5 01 00, then idle 100 cycles → IDLE, `error_o`=1, no `tx_valid_o`.
  - A following good RUN frame clears `error_o` on SYNC and ACKs.
- Back-pressure plus reset:
  - Hold `tx_ready_i`=0 for 50 cycles in RESP → `tx_valid_o`/`tx_data_o` stable; injected rx bytes ignored.
  - Assert `reset` low mid-DATA → all outputs return to reset values asynchronously.
